crc4_frame_sequencer: RTL and testbench
=======================================

Name: crc4_frame_sequencer

Overview:
Controller that sequences the team's serial CRC4 engine over byte-framed data. Accepts bytes on a valid/ready stream with an end-of-frame marker and clears the engine at frame start. Serializes each byte into the engine one bit per cycle, then captures the 4-bit checksum and presents it on a valid/ready result port. Sits between the packet byte stream and the serial CRC4 engine (s_in/en/rst/checksum).

Parameters:
DATA_W, 8, bits per input word; 1..16.
MSB_FIRST, 1, 1 = serialize bit DATA_W-1 first; 0 = bit 0 first.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
s_data  in  DATA_W  input word.
s_last  in  1  word is last of frame; sampled with s_data.
s_valid  in  1  input word valid.
s_ready  out  1  sequencer can accept a word.
crc_s_in  out  1  serial bit to engine.
crc_en  out  1  engine shift enable.
crc_rst  out  1  engine synchronous clear.
crc_checksum  in  4  engine state; bit3 = s[3].
m_crc  out  4  captured frame checksum.
m_valid  out  1  m_crc valid.
m_ready  in  1  consumer accepts m_crc.
busy  out  1  frame in progress (any state except IDLE).

Behaviour:
- Engine model (for verification): while en=1, each edge: fb=in^s0; s3<=fb; s2<=fb^s3; s1<=s2; s0<=s1. Cleared to 0 by rst.
- States: IDLE, NEXT, SHIFT, AUG (feature only), CAPTURE, RESULT.
- Reset: state IDLE; m_valid=0, m_crc=0, s_ready=0 during the rst cycle, crc_en=0, crc_s_in=0; crc_rst=1 whenever rst=1. Reset mid-frame discards the frame with no m_valid.
- IDLE: s_ready=1. On s_valid&&s_ready: load shift reg, latch s_last, crc_rst=1 (combinational, same cycle), go to SHIFT.
- NEXT: s_ready=1, crc_rst=0. On accept: load, latch s_last, go to SHIFT.
- SHIFT: exactly DATA_W cycles, crc_en=1, crc_s_in=current bit per MSB_FIRST; s_ready=0. After the final bit: latched last=0 -> NEXT; last=1 -> AUG (feature on) or CAPTURE.
- CAPTURE: 1 cycle, crc_en=0; m_crc<=crc_checksum; go to RESULT.
- RESULT: m_valid=1, m_crc stable; s_ready=0. On m_ready -> IDLE (m_valid low next cycle). m_ready ignored outside RESULT.
- Latency: first word accepted at cycle T; bits on T+1..T+DATA_W; CAPTURE at T+DATA_W+1; m_valid first high at T+DATA_W+2 for a 1-word frame. Each extra word adds at least 1+DATA_W cycles. Throughput is 1 word per DATA_W+1 cycles.
- s_valid dropping in NEXT holds the state indefinitely, with the engine state preserved (crc_en=0).
- s_data/s_last are ignored whenever s_ready=0. No input is accepted while in RESULT.
- crc_en and crc_rst are never both high.

Optional Feature:
CRC4_AUGMENT_EN: when defined, state AUG follows the last word's SHIFT: 4 cycles with crc_en=1, crc_s_in=0, then CAPTURE. This adds 4 cycles of latency. When undefined, the AUG state does not exist and SHIFT goes directly to CAPTURE.

Test Plan:
- Reset then single word 0x00, last=1 (defaults) -> crc_rst pulse on the accept cycle, 8 crc_en cycles with crc_s_in=0, m_valid at T+10, m_crc=0x0.
- Single word 0x80, last=1, MSB_FIRST=1 -> crc_s_in sequence 1,0,0,0,0,0,0,0; m_crc=0x7. Hold m_ready=0 for 5 cycles -> m_valid and m_crc stay stable, s_ready=0.
- Single word 0x01, last=1 -> m_crc=0xC. With CRC4_AUGMENT_EN -> 4 extra zero-bit cycles, m_crc=0xA, m_valid at T+14.
- Two-word frame 0x00 then 0x01 (last on the 2nd), with a 3-cycle s_valid gap between them -> busy stays high, no crc_rst on the 2nd accept, m_crc=0xC.
- rst asserted during the 4th SHIFT cycle -> next cycle in IDLE, m_valid=0, crc_rst=1 while rst high. A fresh 0x80 frame then yields 0x7.
- Back-to-back frames, with m_ready asserted in the same cycle m_valid rises -> IDLE the next cycle, s_ready=1. The second frame's first accept pulses crc_rst.

Source files
------------

// File: rtl/crc4_frame_sequencer_if.sv
// crc4_frame_sequencer_if
//   Stream-side bundle for the CRC4 frame sequencer.
//   s_*  : byte/word input stream (valid/ready, s_last marks end of frame).
//   m_*  : checksum result stream (valid/ready).
//   master modport = producer of words / consumer of results.
//   slave  modport = the sequencer itself.
interface crc4_frame_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;
  logic [3:0]        m_crc;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output s_data, s_last, s_valid, m_ready,
    input  s_ready, m_crc, m_valid
  );

  modport slave (
    input  s_data, s_last, s_valid, m_ready,
    output s_ready, m_crc, m_valid
  );
endinterface

// File: rtl/crc4_frame_sequencer.sv
// crc4_frame_sequencer
//   Drives a bit-serial CRC4 engine from a word-framed valid/ready stream.
//   The engine is cleared on the first accepted word of a frame, each word is
//   shifted in one bit per cycle, and after the last word the engine state is
//   captured and offered on the result port.
//
//   Parameters : DATA_W    bits per input word (1..16)
//                MSB_FIRST 1 = bit DATA_W-1 first, 0 = bit 0 first
//   Macro      : CRC4_AUGMENT_EN - when defined, four zero bits are appended
//                after the last word before the checksum is captured.
//   Ports      : clk, rst        clock / synchronous active-high reset
//                bus (slave)     s_data/s_last/s_valid/s_ready input stream,
//                                m_crc/m_valid/m_ready result stream
//                crc_s_in        serial bit to engine
//                crc_en          engine shift enable
//                crc_rst         engine synchronous clear
//                crc_checksum    engine state (bit3 = s[3])
//                busy            frame in progress (state != IDLE)
module crc4_frame_sequencer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  crc4_frame_sequencer_if.slave        bus,
  output logic                         crc_s_in,
  output logic                         crc_en,
  output logic                         crc_rst,
  input  logic [3:0]                   crc_checksum,
  output logic                         busy
);

  // Counter is shared between the bit count of SHIFT and the 4-cycle AUG
  // phase, so it must hold max(DATA_W-1, 3).
  localparam int             CW       = $clog2(DATA_W + 4);
  localparam logic [CW-1:0]  BIT_LAST = CW'(DATA_W - 1);

`ifdef CRC4_AUGMENT_EN
  localparam logic [CW-1:0]  AUG_LAST = CW'(3);
  typedef enum logic [2:0] {
    IDLE, NEXT, SHIFT, AUG, CAPTURE, RESULT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, NEXT, SHIFT, CAPTURE, RESULT
  } state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;
  logic              last_q;
  logic              en_q;
  logic              mval_q;
  logic [3:0]        mcrc_q;
  logic              cur_bit;
  logic              accept;

  assign cur_bit     = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];

  // Ready is withheld during the reset cycle even though the state may
  // already read IDLE.
  assign bus.s_ready = !rst && (state == IDLE || state == NEXT);
  assign accept      = bus.s_ready && bus.s_valid;

  // Clear the engine combinationally on the first word of a frame so the
  // first data bit on the next cycle shifts into a zero state.
  assign crc_rst     = rst || (accept && state == IDLE);

  // Reset gates the registered enables so crc_en and crc_rst never overlap
  // when reset lands mid-frame.
  assign crc_en      = en_q && !rst;
  assign crc_s_in    = crc_en && (state == SHIFT) && cur_bit;

  assign bus.m_valid = mval_q && !rst;
  assign bus.m_crc   = rst ? 4'h0 : mcrc_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
      en_q   <= 1'b0;
      mval_q <= 1'b0;
      mcrc_q <= 4'h0;
    end else begin
      unique case (state)
        IDLE, NEXT: begin
          if (accept) begin
            sreg   <= bus.s_data;
            last_q <= bus.s_last;
            cnt    <= '0;
            en_q   <= 1'b1;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          // Shifting zeros in keeps cur_bit at 0 once the word is consumed.
          sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (last_q) begin
`ifdef CRC4_AUGMENT_EN
              state <= AUG;
`else
              en_q  <= 1'b0;
              state <= CAPTURE;
`endif
            end else begin
              // Engine state is held in NEXT until the next word arrives.
              en_q  <= 1'b0;
              state <= NEXT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef CRC4_AUGMENT_EN
        AUG: begin
          if (cnt == AUG_LAST) begin
            cnt   <= '0;
            en_q  <= 1'b0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        CAPTURE: begin
          // Engine is idle this cycle, so crc_checksum is the final value.
          mcrc_q <= crc_checksum;
          mval_q <= 1'b1;
          state  <= RESULT;
        end

        RESULT: begin
          if (bus.m_ready) begin
            mval_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          en_q   <= 1'b0;
          mval_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc4_frame_sequencer.sv
// tb_crc4_frame_sequencer
//   Directed bench for crc4_frame_sequencer (DATA_W=8, MSB_FIRST=1) with a
//   behavioural CRC4 engine attached to the crc_* pins. Single-word frames
//   come from a vector table; multi-word, mid-frame reset and back-to-back
//   cases are hand-written sequences.
module tb_crc4_frame_sequencer;

  localparam int DW = 8;
`ifdef CRC4_AUGMENT_EN
  localparam int AUG_CYC = 4;
`else
  localparam int AUG_CYC = 0;
`endif

  logic       clk;
  logic       rst;
  logic       crc_s_in;
  logic       crc_en;
  logic       crc_rst;
  logic [3:0] crc_checksum;
  logic       busy;

  crc4_frame_sequencer_if #(.DATA_W(DW)) bus ();

  crc4_frame_sequencer #(.DATA_W(DW), .MSB_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .crc_s_in     (crc_s_in),
    .crc_en       (crc_en),
    .crc_rst      (crc_rst),
    .crc_checksum (crc_checksum),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial CRC4 engine: fb = in ^ s0; s3<=fb; s2<=fb^s3; s1<=s2; s0<=s1.
  logic [3:0] eng = 4'h0;
  logic       fb;
  assign fb           = crc_s_in ^ eng[0];
  assign crc_checksum = eng;
  always @(posedge clk) begin
    if (crc_rst)     eng <= 4'h0;
    else if (crc_en) eng <= {fb, fb ^ eng[3], eng[2], eng[1]};
  end

  typedef struct {
    logic [7:0] data;
    logic [3:0] crc;
    logic [3:0] crc_aug;
    int         hold;
  } vec_t;

  vec_t tbl [4];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pick(input logic [3:0] plain, input logic [3:0] aug);
    return (AUG_CYC != 0) ? aug : plain;
  endfunction

  // Called in the cycle the DUT sits in IDLE; leaves the bench in the
  // IDLE cycle that follows the result handshake.
  task automatic run_frame(input logic [7:0] d, input logic [3:0] exp, input int hold);
    bus.s_data  = d;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    #1;
    chk("idle_s_ready", bus.s_ready, 1);
    chk("accept_crc_rst", crc_rst, 1);
    chk("accept_crc_en", crc_en, 0);
    tick;
    bus.s_valid = 1'b0;
    bus.s_data  = ~d;
    bus.s_last  = 1'b0;
    for (int i = 0; i < DW; i++) begin
      #1;
      chk("shift_en", crc_en, 1);
      chk("shift_bit", crc_s_in, d[DW-1-i]);
      chk("shift_rst", crc_rst, 0);
      chk("shift_s_ready", bus.s_ready, 0);
      tick;
    end
    for (int i = 0; i < AUG_CYC; i++) begin
      #1;
      chk("aug_en", crc_en, 1);
      chk("aug_bit", crc_s_in, 0);
      tick;
    end
    #1;
    chk("capture_en", crc_en, 0);
    chk("capture_m_valid", bus.m_valid, 0);
    tick;
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("hold_m_valid", bus.m_valid, 1);
      chk("hold_m_crc", bus.m_crc, exp);
      chk("hold_s_ready", bus.s_ready, 0);
      chk("hold_busy", busy, 1);
      tick;
    end
    bus.m_ready = 1'b1;
    #1;
    chk("result_m_valid", bus.m_valid, 1);
    chk("result_m_crc", bus.m_crc, exp);
    tick;
    bus.m_ready = 1'b0;
    #1;
    chk("done_m_valid", bus.m_valid, 0);
    chk("done_s_ready", bus.s_ready, 1);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    tbl[0] = '{8'h00, 4'h0, 4'h0, 0};
    tbl[1] = '{8'h80, 4'h7, 4'h7, 5};
    tbl[2] = '{8'h01, 4'hC, 4'hA, 1};
    tbl[3] = '{8'hFF, 4'h2, 4'h3, 0};

    rst         = 1'b1;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;

    // Reset state
    tick;
    chk("rst_crc_rst", crc_rst, 1);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_crc_en", crc_en, 0);
    chk("rst_crc_s_in", crc_s_in, 0);
    chk("rst_m_crc", bus.m_crc, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_s_ready", bus.s_ready, 1);
    chk("post_rst_crc_rst", crc_rst, 0);

    // Single-word frames, run back to back: m_ready is raised in the cycle
    // m_valid first rises when hold==0.
    for (int v = 0; v < 4; v++)
      run_frame(tbl[v].data, pick(tbl[v].crc, tbl[v].crc_aug), tbl[v].hold);

    // Two-word frame with a 3-cycle s_valid gap between words.
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.s_valid = 1'b1;
    #1;
    chk("w1_crc_rst", crc_rst, 1);
    tick;
    bus.s_valid = 1'b0;
    for (int i = 0; i < DW; i++) tick;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("gap_busy", busy, 1);
      chk("gap_s_ready", bus.s_ready, 1);
      chk("gap_crc_en", crc_en, 0);
      chk("gap_crc_rst", crc_rst, 0);
      tick;
    end
    bus.s_data  = 8'h01;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    #1;
    chk("w2_s_ready", bus.s_ready, 1);
    chk("w2_crc_rst", crc_rst, 0);
    tick;
    bus.s_valid = 1'b0;
    for (int i = 0; i < DW + AUG_CYC + 1; i++) tick;
    #1;
    chk("w2_m_valid", bus.m_valid, 1);
    chk("w2_m_crc", bus.m_crc, pick(4'hC, 4'hA));
    chk("w2_busy", busy, 1);
    bus.m_ready = 1'b1;
    tick;
    bus.m_ready = 1'b0;

    // Reset asserted in the 4th SHIFT cycle discards the frame.
    bus.s_data  = 8'h80;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    #1;
    tick;
    bus.s_valid = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("midrst_crc_rst", crc_rst, 1);
    chk("midrst_crc_en", crc_en, 0);
    chk("midrst_s_ready", bus.s_ready, 0);
    chk("midrst_m_valid", bus.m_valid, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("after_rst_busy", busy, 0);
    chk("after_rst_m_valid", bus.m_valid, 0);
    chk("after_rst_s_ready", bus.s_ready, 1);
    run_frame(8'h80, pick(4'h7, 4'h7), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
